// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with read-latency tracking.
// Optional grant statistics are built when the ARB_STATS_EN macro is defined.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    input  logic        if_flush,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_write,
    input  logic [31:0] d_req_wdata,
    input  logic [1:0]  d_req_size,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        mem_enable,
    output logic        mem_read_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_out,
    output logic [15:0] stat_if_grants,
    output logic [15:0] stat_d_grants
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned SW = 16;

    typedef struct packed {
        logic valid;
        logic owner_d;
        logic killed;
    } pipe_entry_t;

    logic [CW-1:0] starve_q, starve_d;
    pipe_entry_t   pipe_q [MEM_LATENCY];
    pipe_entry_t   pipe_d [MEM_LATENCY];
    pipe_entry_t   head;
    logic          gnt_if, gnt_d, if_favoured;

    // Data normally wins; fetch is forced ahead once it has lost STARVE_LIMIT times in a row.
    always_comb begin
        if_favoured = (starve_q == CW'(STARVE_LIMIT));
        gnt_if      = reset_n & if_req_valid & (~d_req_valid | if_favoured);
        gnt_d       = reset_n & d_req_valid & ~gnt_if;
    end

    assign if_req_ready = gnt_if;
    assign d_req_ready  = gnt_d;

    always_comb begin
        mem_enable      = 1'b0;
        mem_read_write  = 1'b0;
        mem_address     = '0;
        mem_data_in     = '0;
        mem_access_size = 2'b00;
        if (gnt_if) begin
            mem_enable      = 1'b1;
            mem_address     = AW'(if_req_addr);
            mem_access_size = 2'b10;
        end else if (gnt_d) begin
            mem_enable      = 1'b1;
            mem_read_write  = d_req_write;
            mem_address     = AW'(d_req_addr);
            mem_data_in     = DW'(d_req_wdata);
            mem_access_size = d_req_size;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req_valid || gnt_if) begin
            starve_d = '0;
        end else if (gnt_d && (starve_q < CW'(STARVE_LIMIT))) begin
            starve_d = starve_q + CW'(1);
        end
    end

    // Stores enter as invalid so they shift through without producing a response.
    always_comb begin
        pipe_d[0].valid   = gnt_if | (gnt_d & ~d_req_write);
        pipe_d[0].owner_d = gnt_d;
        pipe_d[0].killed  = 1'b0;
        for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
            if (if_flush && !pipe_q[i-1].owner_d) begin
                pipe_d[i].killed = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            starve_q <= starve_d;
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // A flush in the response cycle also kills the fetch at the head.
    always_comb begin
        head         = pipe_q[MEM_LATENCY-1];
        if_rsp_valid = head.valid & ~head.owner_d & ~head.killed & ~if_flush;
        d_rsp_valid  = head.valid & head.owner_d;
        if_rsp_data  = if_rsp_valid ? mem_data_out : '0;
        d_rsp_data   = d_rsp_valid ? mem_data_out : '0;
    end

`ifdef ARB_STATS_EN
    logic [SW-1:0] stat_if_q, stat_d_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_if_q <= '0;
            stat_d_q  <= '0;
        end else begin
            if (gnt_if) stat_if_q <= stat_if_q + SW'(1);
            if (gnt_d)  stat_d_q  <= stat_d_q + SW'(1);
        end
    end

    assign stat_if_grants = stat_if_q;
    assign stat_d_grants  = stat_d_q;
`else
    assign stat_if_grants = SW'(0);
    assign stat_d_grants  = SW'(0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_mem_port_arbiter;

    localparam int LAT = 3;
    localparam int SL  = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req_valid, if_req_ready, if_flush, if_rsp_valid;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_write, d_rsp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic [1:0]  d_req_size;
    logic        mem_enable, mem_read_write;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic [1:0]  mem_access_size;
    logic [15:0] stat_if_grants, stat_d_grants;

    always #5 clock = ~clock;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_write(d_req_write), .d_req_wdata(d_req_wdata), .d_req_size(d_req_size),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_enable(mem_enable), .mem_read_write(mem_read_write), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_access_size(mem_access_size), .mem_data_out(mem_data_out),
        .stat_if_grants(stat_if_grants), .stat_d_grants(stat_d_grants)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int starve  = 0;
    logic [15:0] st_if = 16'd0;
    logic [15:0] st_d  = 16'd0;

    // Reference state: memory contents, read data scheduled per cycle, expected responses per cycle.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rdq [int];
    bit          sched_own [int];
    bit          sched_kill [int];
    logic [31:0] sched_dat [int];

    bit          s_ifv, s_dv, s_dw, s_fl;
    logic [31:0] s_ifa, s_da, s_dwd;
    logic [1:0]  s_dsz;
    bit          g_if, g_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_if_ready"}, 32'(if_req_ready), 32'h0);
        check({tag, "_d_ready"}, 32'(d_req_ready), 32'h0);
        check({tag, "_mem_enable"}, 32'(mem_enable), 32'h0);
        check({tag, "_if_rsp_valid"}, 32'(if_rsp_valid), 32'h0);
        check({tag, "_d_rsp_valid"}, 32'(d_rsp_valid), 32'h0);
        check({tag, "_stat_if"}, 32'(stat_if_grants), 32'h0);
        check({tag, "_stat_d"}, 32'(stat_d_grants), 32'h0);
    endtask

    task automatic idle_stim();
        s_ifv = 1'b0; s_dv = 1'b0; s_dw = 1'b0; s_fl = 1'b0;
        s_ifa = 32'h0; s_da = 32'h0; s_dwd = 32'h0; s_dsz = 2'b00;
    endtask

    task automatic model_clear();
        rdq.delete(); sched_own.delete(); sched_kill.delete(); sched_dat.delete();
        starve = 0; st_if = 16'd0; st_d = 16'd0;
    endtask

    // One clock cycle: drive, compare every output with the model, then advance the model.
    task automatic step();
        bit ev_i, ev_d;
        logic [31:0] ed, ea, rv, exp_addr;
        logic [1:0]  exp_size;
        @(negedge clock);
        if_req_valid = s_ifv; if_req_addr = s_ifa; if_flush = s_fl;
        d_req_valid = s_dv; d_req_addr = s_da; d_req_write = s_dw;
        d_req_wdata = s_dwd; d_req_size = s_dsz;
        mem_data_out = rdq.exists(cyc) ? rdq[cyc] : $urandom();
        #1;
        if (s_fl) begin
            foreach (sched_own[k]) if (k >= cyc && !sched_own[k]) sched_kill[k] = 1'b1;
        end
        ev_i = 1'b0; ev_d = 1'b0; ed = 32'h0;
        if (sched_own.exists(cyc)) begin
            ed = sched_dat[cyc];
            if (sched_own[cyc]) ev_d = 1'b1;
            else ev_i = !sched_kill[cyc];
        end
        g_if = s_ifv && (!s_dv || starve == SL);
        g_d  = s_dv && !g_if;
        exp_addr = g_if ? s_ifa : (g_d ? s_da : 32'h0);
        exp_size = g_if ? 2'b10 : (g_d ? s_dsz : 2'b00);
        check("if_req_ready", 32'(if_req_ready), 32'(g_if));
        check("d_req_ready", 32'(d_req_ready), 32'(g_d));
        check("mem_enable", 32'(mem_enable), 32'(g_if | g_d));
        check("mem_address", mem_address, exp_addr);
        check("mem_read_write", 32'(mem_read_write), 32'(g_d & s_dw));
        check("mem_access_size", 32'(mem_access_size), 32'(exp_size));
        if (g_d) check("mem_data_in", mem_data_in, s_dwd);
        else if (!g_if) check("mem_data_in_idle", mem_data_in, 32'h0);
        check("if_rsp_valid", 32'(if_rsp_valid), 32'(ev_i));
        check("if_rsp_data", if_rsp_data, ev_i ? ed : 32'h0);
        check("d_rsp_valid", 32'(d_rsp_valid), 32'(ev_d));
        check("d_rsp_data", d_rsp_data, ev_d ? ed : 32'h0);
`ifdef ARB_STATS_EN
        check("stat_if_grants", 32'(stat_if_grants), 32'(st_if));
        check("stat_d_grants", 32'(stat_d_grants), 32'(st_d));
`else
        check("stat_if_grants", 32'(stat_if_grants), 32'h0);
        check("stat_d_grants", 32'(stat_d_grants), 32'h0);
`endif
        if (!s_ifv || g_if) starve = 0;
        else if (g_d) starve++;
        if (g_if) st_if = st_if + 16'd1;
        if (g_d) st_d = st_d + 16'd1;
        ea = g_if ? s_ifa : s_da;
        if (g_d && s_dw) begin
            mem[s_da] = s_dwd;
        end else if (g_if || g_d) begin
            rv = mem.exists(ea) ? mem[ea] : (ea ^ 32'h5A5A0F0F);
            rdq[cyc + LAT] = rv;
            sched_own[cyc + LAT] = g_d;
            sched_kill[cyc + LAT] = 1'b0;
            sched_dat[cyc + LAT] = rv;
        end
        rdq.delete(cyc); sched_own.delete(cyc); sched_kill.delete(cyc); sched_dat.delete(cyc);
        cyc++;
    endtask

    // Asynchronous reset mid-cycle with both requesters asserting.
    task automatic async_reset();
        @(negedge clock);
        if_req_valid = 1'b1; d_req_valid = 1'b1; d_req_write = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_quiet("async_rst");
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        model_clear();
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b1;
        cyc += 3;
    endtask

    logic [0:9] pat;
    int nrsp;

    initial begin
        idle_stim();
        if_req_valid = 1'b1; d_req_valid = 1'b1; if_flush = 1'b0;
        if_req_addr = 32'h0; d_req_addr = 32'h0; d_req_write = 1'b0;
        d_req_wdata = 32'h0; d_req_size = 2'b00; mem_data_out = 32'h0;
        #3 check_quiet("por");
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b1;

        // Fetch-only stream.
        for (int i = 0; i < 3; i++) begin
            s_ifv = 1'b1; s_ifa = 32'h01000000 + 32'(i * 4);
            step();
        end
        idle_stim();
        for (int i = 0; i < LAT + 1; i++) step();

        // Both requesters contending for 10 cycles.
        pat = 10'b1111011110;
        s_ifv = 1'b1; s_ifa = 32'h01000040; s_dv = 1'b1; s_da = 32'h01000200; s_dsz = 2'b10;
        for (int i = 0; i < 10; i++) begin
            step();
            check("contend_order", 32'(d_req_ready), 32'(pat[i]));
        end
        idle_stim();
        for (int i = 0; i < LAT + 1; i++) step();

        // Store then load of the same word.
        s_dv = 1'b1; s_dw = 1'b1; s_da = 32'h01000100; s_dwd = 32'hDEADBEEF; s_dsz = 2'b10;
        step();
        s_dw = 1'b0; s_dwd = 32'h0;
        step();
        idle_stim();
        for (int i = 0; i < LAT; i++) step();
        check("load_after_store_valid", 32'(d_rsp_valid), 32'h1);
        check("load_after_store_data", d_rsp_data, 32'hDEADBEEF);
        for (int i = 0; i < 2; i++) step();

        // Flush with a redirect fetch accepted in the flush cycle.
        s_ifv = 1'b1; s_ifa = 32'h01000010; step();
        s_ifa = 32'h01000014; step();
        s_ifa = 32'h01000080; s_fl = 1'b1; step();
        idle_stim();
        nrsp = 0;
        for (int i = 0; i < LAT; i++) begin
            step();
            nrsp += int'(if_rsp_valid);
        end
        check("flush_rsp_count", 32'(nrsp), 32'h1);
        check("flush_target_rsp", 32'(if_rsp_valid), 32'h1);
        for (int i = 0; i < 2; i++) step();

        // Reset with reads in flight, then immediate fetch grant.
        s_ifv = 1'b1; s_ifa = 32'h01000020; step();
        s_ifv = 1'b0; s_dv = 1'b1; s_da = 32'h01000024; s_dsz = 2'b10; step();
        async_reset();
        idle_stim();
        s_ifv = 1'b1; s_ifa = 32'h01000000; step();
        check("first_grant_after_reset", 32'(if_req_ready), 32'h1);
        s_ifv = 1'b0;
        for (int i = 0; i < LAT + 2; i++) step();

        // Grant statistics after a fresh reset.
        async_reset();
        idle_stim();
        for (int i = 0; i < 3; i++) begin
            s_ifv = 1'b1; s_ifa = 32'h01000000 + 32'(i * 4); step();
        end
        s_ifv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_dv = 1'b1; s_da = 32'h01000300 + 32'(i * 4); s_dsz = 2'b10; step();
        end
        idle_stim();
        step();
`ifdef ARB_STATS_EN
        check("stats_if_total", 32'(stat_if_grants), 32'h3);
        check("stats_d_total", 32'(stat_d_grants), 32'h2);
`else
        check("stats_if_off", 32'(stat_if_grants), 32'h0);
        check("stats_d_off", 32'(stat_d_grants), 32'h0);
`endif
        for (int i = 0; i < LAT; i++) step();

        // Randomized traffic; requests are held until accepted.
        g_if = 1'b0; g_d = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!s_ifv || g_if) begin
                s_ifv = 1'($urandom_range(0, 1));
                s_ifa = 32'h01000000 + (32'($urandom_range(0, 15)) << 2);
            end
            if (!s_dv || g_d) begin
                s_dv  = 1'($urandom_range(0, 1));
                s_da  = 32'h01000000 + (32'($urandom_range(0, 15)) << 2);
                s_dw  = 1'($urandom_range(0, 1));
                s_dwd = $urandom();
                s_dsz = 2'($urandom_range(0, 2));
            end
            s_fl = ($urandom_range(0, 9) == 0);
            step();
        end
        idle_stim();
        for (int i = 0; i < LAT + 1; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester and the load/store requester of the 5-stage pipeline.
- Issues at most one memory access per cycle and tracks in-flight reads through a latency pipe.
- Routes each read response back to its owner.
- Drops fetch responses made stale by a taken branch or jump.

Parameters:
MEM_LATENCY, 1, cycles from accepted read to mem_data_out valid (legal 1..4)
STARVE_LIMIT, 4, consecutive contested data grants before fetch is forced ahead (legal 1..15)

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
if_req_valid  input  1  fetch request
if_req_ready  output  1  fetch request accepted this cycle
if_req_addr  input  32  fetch address
if_flush  input  1  pipeline redirect; kills older in-flight fetches
if_rsp_valid  output  1  fetch data valid
if_rsp_data  output  32  fetched instruction
d_req_valid  input  1  load/store request
d_req_ready  output  1  data request accepted this cycle
d_req_addr  input  32  data address
d_req_write  input  1  1 = store, 0 = load
d_req_wdata  input  32  store data
d_req_size  input  2  access size: 00 byte, 01 half, 10 word
d_rsp_valid  output  1  load data valid
d_rsp_data  output  32  raw load data; sign/zero extension stays in the pipeline
mem_enable  output  1  memory access this cycle
mem_read_write  output  1  1 = write
mem_address  output  32  memory address
mem_data_in  output  32  memory write data
mem_access_size  output  2  memory access size
mem_data_out  input  32  memory read data, valid MEM_LATENCY cycles after the access
stat_if_grants  output  16  fetch grant count (see Optional Feature)
stat_d_grants  output  16  data grant count (see Optional Feature)

Behaviour:
- Handshake: a request is accepted when valid and ready are both high in the same cycle.
  - Requesters hold addr/data/size stable until accepted.
  - Ready outputs are combinational from the valids and the arbitration state.
  - At most one ready is high per cycle; a ready is never high without its valid.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt (4-bit register):
  - Increments when both valids are high and data is granted.
  - Clears when fetch is granted or when if_req_valid is low.
  - Never exceeds STARVE_LIMIT.
- Memory drive on the grant cycle:
  - mem_enable = 1 and mem_address = the granted address.
  - Fetch: mem_read_write = 0, mem_access_size = 2'b10.
  - Data: mem_read_write = d_req_write, mem_access_size = d_req_size, mem_data_in = d_req_wdata.
  - No grant: mem_enable = 0, mem_read_write = 0, other memory outputs 0.
- Latency pipe:
  - MEM_LATENCY-deep shift register of {valid, owner, killed} entries.
  - On a grant, enters valid = 1 for reads; stores enter valid = 0, so stores produce no response.
  - When the head entry is valid and not killed, raise the owner's rsp_valid for exactly one cycle, with rsp_data = mem_data_out.
  - The non-owner rsp_valid stays 0; both rsp_data outputs carry 0 when not valid.
- Flush:
  - if_flush high in cycle T sets killed on every fetch entry accepted before T; those entries never produce if_rsp_valid.
  - A fetch accepted in cycle T itself (the redirect target) is not killed.
  - Data entries are never killed.
- Back-to-back: one access per cycle with no bubbles. Throughput is 1 per cycle, shared between the two requesters.
- Reset (reset_n low), asynchronous, including mid-operation:
  - Pipe cleared; starve_cnt = 0; stat counters = 0.
  - All ready, rsp_valid and mem_enable outputs = 0.
  - Nothing in flight at reset produces a response after release.
  - The first grant is possible in the first cycle after reset_n rises.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: stat_if_grants and stat_d_grants each increment by 1 per accepted request of their side, wrap from 16'hFFFF to 0, and clear on reset.
- Undefined: no counter logic is built and both stat outputs are tied to 0.

Test Plan:
1. Fetch only, addresses 0x01000000, 0x01000004, 0x01000008 in consecutive cycles, MEM_LATENCY = 1 -> if_req_ready high all three cycles; if_rsp_valid in the three following cycles with the memory words; d_rsp_valid stays 0.
2. Both valid for 10 cycles, STARVE_LIMIT = 4 -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt never exceeds 4.
3. Store 0xDEADBEEF to 0x01000100 (size 10), then load from 0x01000100 -> memory sees write then read; d_rsp_valid once, with d_rsp_data = 0xDEADBEEF; no response for the store.
4. MEM_LATENCY = 3: fetches at cycles 0, 1, 2, if_flush at cycle 2 with a fetch also accepted at cycle 2 -> only the cycle-2 fetch responds, at cycle 5.
5. Assert reset_n low asynchronously with two reads in flight -> all outputs 0 immediately; no rsp_valid after release; a fetch is granted in the first cycle after release.
6. With ARB_STATS_EN defined: run 3 fetch and 2 data grants -> stat_if_grants = 3, stat_d_grants = 2. Without the macro -> both read 0.
